// File: rtl/k12a_lcd_pkg.sv
// ============================================================================
// Module  : k12a_lcd_pkg
// Purpose : Shared LCD sequencer types, command constants and decode helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package k12a_lcd_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      PULSE = 3'd2,
      HOLD  = 3'd3,
      EXEC  = 3'd4
   } lcd_state_t;

   localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
   localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

   // Return-home ignores bit 0, so 0x03 is also a long command.
   function automatic logic lcd_long_exec(input logic rs, input logic [7:0] data);
      return !rs && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME) || (data == 8'h03));
   endfunction

   function automatic int lcd_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/k12a_lcd_fifo.sv
// ============================================================================
// Module  : k12a_lcd_fifo
// Purpose : Small request FIFO; a push while full is accepted only with a pop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module k12a_lcd_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic                       cpu_clock,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int c_ptr_w = $clog2(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w:0]   r_count;
   logic               w_wr;
   logic               w_rd;

   assign full  = (r_count == DEPTH[c_ptr_w:0]);
   assign empty = (r_count == '0);
   assign count = r_count;
   assign rdata = r_mem[r_rd_ptr];

   assign w_rd = pop & ~empty;
   assign w_wr = push & (~full | w_rd);

   always_ff @(posedge cpu_clock) begin
      if (w_wr) r_mem[r_wr_ptr] <= wdata;
   end

   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/k12a_lcd_ctrl.sv
// ============================================================================
// Module  : k12a_lcd_ctrl
// Purpose : HD44780 write sequencer: buffers {rs,data} requests, drives timed
//           setup / enable pulse / hold / execution-wait on the LCD pins.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module k12a_lcd_ctrl
   import k12a_lcd_pkg::*;
#(
   parameter int SETUP_CYCLES     = 1,
   parameter int PULSE_CYCLES     = 1,
   parameter int HOLD_CYCLES      = 1,
   parameter int EXEC_CYCLES      = 40,
   parameter int LONG_EXEC_CYCLES = 1600,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic       cpu_clock,
   input  logic       reset_n,
   input  logic       wr_strobe,
   input  logic       wr_rs,
   input  logic [7:0] wr_data,
   input  logic       clr_overflow,
   output logic       busy,
   output logic       full,
   output logic       overflow,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic [7:0] lcd_data
);

   localparam int c_max_cycles = lcd_max(lcd_max(lcd_max(SETUP_CYCLES, PULSE_CYCLES),
                                                 lcd_max(HOLD_CYCLES, EXEC_CYCLES)),
                                         LONG_EXEC_CYCLES);
   localparam int c_cnt_w = $clog2(c_max_cycles) + 1;

   localparam logic [c_cnt_w-1:0] c_setup_ld = c_cnt_w'(SETUP_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_pulse_ld = c_cnt_w'(PULSE_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_hold_ld  = c_cnt_w'(HOLD_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_exec_ld  = c_cnt_w'(EXEC_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_long_ld  = c_cnt_w'(LONG_EXEC_CYCLES - 1);

   lcd_state_t                  r_state;
   lcd_state_t                  w_next;
   logic [c_cnt_w-1:0]          r_cnt;
   logic [c_cnt_w-1:0]          w_cnt_next;
   logic                        w_cnt_zero;
   logic                        w_pop;
   logic                        w_drop;
   logic                        r_lcd_en;
   logic                        r_lcd_rs;
   logic [7:0]                  r_lcd_data;
   logic                        r_overflow;
   logic [8:0]                  w_head;
   logic                        w_fifo_full;
   logic                        w_fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

   k12a_lcd_fifo #(
      .WIDTH (9),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .cpu_clock (cpu_clock),
      .reset_n   (reset_n),
      .push      (wr_strobe),
      .pop       (w_pop),
      .wdata     ({wr_rs, wr_data}),
      .rdata     (w_head),
      .full      (w_fifo_full),
      .empty     (w_fifo_empty),
      .count     (w_fifo_count)
   );

   assign w_cnt_zero = (r_cnt == '0);

   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (!w_fifo_empty) w_next = SETUP;
         SETUP:   if (w_cnt_zero)    w_next = PULSE;
         PULSE:   if (w_cnt_zero)    w_next = HOLD;
         HOLD:    if (w_cnt_zero)    w_next = EXEC;
         EXEC:    if (w_cnt_zero)    w_next = IDLE;
         default:                    w_next = IDLE;
      endcase
   end

   // Each timed state reloads the shared counter on entry to the next one.
   always_comb begin
      w_pop      = 1'b0;
      w_cnt_next = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
      case (r_state)
         IDLE: begin
            w_pop      = ~w_fifo_empty;
            w_cnt_next = w_fifo_empty ? r_cnt : c_setup_ld;
         end
         SETUP: if (w_cnt_zero) w_cnt_next = c_pulse_ld;
         PULSE: if (w_cnt_zero) w_cnt_next = c_hold_ld;
         HOLD:  if (w_cnt_zero) w_cnt_next = lcd_long_exec(r_lcd_rs, r_lcd_data) ? c_long_ld : c_exec_ld;
         default: ;
      endcase
   end

   assign w_drop = wr_strobe & w_fifo_full & ~w_pop;

   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt      <= '0;
         r_lcd_en   <= 1'b0;
         r_lcd_rs   <= 1'b0;
         r_lcd_data <= 8'h00;
         r_overflow <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_next;
         r_lcd_en <= (w_next == PULSE);
         if (w_pop) begin
            r_lcd_rs   <= w_head[8];
            r_lcd_data <= w_head[7:0];
         end
         if (w_drop)            r_overflow <= 1'b1;
         else if (clr_overflow) r_overflow <= 1'b0;
      end
   end

   assign busy     = (w_fifo_count != '0) | (r_state != IDLE);
   assign full     = w_fifo_full;
   assign overflow = r_overflow;
   assign lcd_rs   = r_lcd_rs;
   assign lcd_rw   = 1'b0;
   assign lcd_en   = r_lcd_en;
   assign lcd_data = r_lcd_data;

endmodule

`default_nettype wire

// File: tb/tb_k12a_lcd_ctrl.sv
// ============================================================================
// Module  : tb_k12a_lcd_ctrl
// Purpose : Directed self-checking bench for the LCD write sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_k12a_lcd_ctrl;

   logic       cpu_clock = 1'b0;
   logic       reset_n;
   logic       wr_strobe, wr_rs, clr_overflow;
   logic [7:0] wr_data;
   logic       busy, full, overflow, lcd_rs, lcd_rw, lcd_en;
   logic [7:0] lcd_data;

   logic       b_wr_strobe, b_wr_rs, b_clr_overflow;
   logic [7:0] b_wr_data;
   logic       b_busy, b_full, b_overflow, b_lcd_rs, b_lcd_rw, b_lcd_en;
   logic [7:0] b_lcd_data;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [8:0] cap_q[$];
   logic       prev_en = 1'b0;

   always #5 cpu_clock = ~cpu_clock;

   k12a_lcd_ctrl dut (
      .cpu_clock (cpu_clock), .reset_n (reset_n),
      .wr_strobe (wr_strobe), .wr_rs (wr_rs), .wr_data (wr_data),
      .clr_overflow (clr_overflow),
      .busy (busy), .full (full), .overflow (overflow),
      .lcd_rs (lcd_rs), .lcd_rw (lcd_rw), .lcd_en (lcd_en), .lcd_data (lcd_data)
   );

   k12a_lcd_ctrl #(
      .SETUP_CYCLES (3), .PULSE_CYCLES (2), .HOLD_CYCLES (2),
      .EXEC_CYCLES (4), .LONG_EXEC_CYCLES (8), .FIFO_DEPTH (4)
   ) dut_slow (
      .cpu_clock (cpu_clock), .reset_n (reset_n),
      .wr_strobe (b_wr_strobe), .wr_rs (b_wr_rs), .wr_data (b_wr_data),
      .clr_overflow (b_clr_overflow),
      .busy (b_busy), .full (b_full), .overflow (b_overflow),
      .lcd_rs (b_lcd_rs), .lcd_rw (b_lcd_rw), .lcd_en (b_lcd_en), .lcd_data (b_lcd_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n edges, sampling 1 ns after each; logs every enable rising edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge cpu_clock);
         #1;
         if (lcd_en && !prev_en) cap_q.push_back({lcd_rs, lcd_data});
         prev_en = lcd_en;
      end
   endtask

   task automatic strobe(input logic rs, input logic [7:0] d);
      wr_strobe = 1'b1; wr_rs = rs; wr_data = d;
      tick(1);
      wr_strobe = 1'b0;
   endtask

   // t counts edges after the push edge; busy length includes the IDLE pop cycle.
   task automatic measure(input logic rs, input logic [7:0] d,
                          output int t_busy, output int t_rise, output int t_hi,
                          output logic [8:0] first);
      int t;
      strobe(rs, d);
      t = 0; t_rise = -1; t_hi = 0; first = '0;
      while (busy && t < 2000) begin
         tick(1);
         t++;
         if (t == 1) first = {lcd_rs, lcd_data};
         if (lcd_en) begin
            t_hi++;
            if (t_rise < 0) t_rise = t;
         end
      end
      t_busy = t;
   endtask

   task automatic drain(input int bound);
      int g;
      g = 0;
      while (busy && g < bound) begin
         tick(1);
         g++;
      end
      check("drain_idle", busy, 1'b0);
   endtask

   initial begin
      int         tb, tr, th;
      logic [8:0] f;
      int         t, t_d1, t_r1, t_f1, t_d2, t_r2, hi_tot, rw_bad;

      reset_n = 1'b0; wr_strobe = 1'b0; wr_rs = 1'b0; wr_data = 8'h00; clr_overflow = 1'b0;
      b_wr_strobe = 1'b0; b_wr_rs = 1'b0; b_wr_data = 8'h00; b_clr_overflow = 1'b0;
      tick(3);
      check("rst_busy", busy, 1'b0);
      check("rst_full", full, 1'b0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_en", lcd_en, 1'b0);
      check("rst_rs_data", {lcd_rs, lcd_data}, 9'h000);
      check("rst_rw", lcd_rw, 1'b0);
      reset_n = 1'b1;
      tick(1);

      // Single data write
      measure(1'b1, 8'h41, tb, tr, th, f);
      check("single_first", f, 9'h141);
      check("single_en_rise", tr, 2);
      check("single_en_hi", th, 1);
      check("single_busy", tb, 44);

      // Long-exec decode
      measure(1'b0, 8'h01, tb, tr, th, f);
      check("clear_busy", tb, 1604);
      measure(1'b1, 8'h01, tb, tr, th, f);
      check("data01_busy", tb, 44);
      measure(1'b0, 8'h03, tb, tr, th, f);
      check("home3_busy", tb, 1604);
      measure(1'b0, 8'h04, tb, tr, th, f);
      check("cmd04_busy", tb, 44);

      // Six back-to-back strobes; 6th dropped even with clr_overflow asserted
      cap_q.delete();
      for (int i = 0; i < 6; i++) begin
         wr_strobe = 1'b1; wr_rs = 1'b1; wr_data = 8'hA0 + 8'(i);
         clr_overflow = (i == 5);
         tick(1);
         if (i == 4) check("burst_full", full, 1'b1);
      end
      wr_strobe = 1'b0; clr_overflow = 1'b0;
      check("burst_ovf", overflow, 1'b1);
      check("burst_full_hold", full, 1'b1);
      clr_overflow = 1'b1;
      tick(1);
      clr_overflow = 1'b0;
      check("ovf_cleared", overflow, 1'b0);
      drain(400);
      check("burst_count", cap_q.size(), 5);
      for (int i = 0; i < 5 && i < cap_q.size(); i++)
         check($sformatf("burst_order%0d", i), cap_q[i], 9'h1A0 + 9'(i));

      // Strobe while full on the same edge as the IDLE pop
      cap_q.delete();
      for (int i = 0; i < 5; i++) begin
         wr_strobe = 1'b1; wr_rs = 1'b1; wr_data = 8'h10 + 8'(i);
         tick(1);
      end
      wr_strobe = 1'b0;
      check("pp_full_pre", full, 1'b1);
      tick(40);
      wr_strobe = 1'b1; wr_data = 8'h15;
      tick(1);
      wr_strobe = 1'b0;
      check("pp_full_post", full, 1'b1);
      check("pp_ovf", overflow, 1'b0);
      check("pp_popped", lcd_data, 8'h11);
      drain(400);
      check("pp_count", cap_q.size(), 6);
      for (int i = 0; i < 6 && i < cap_q.size(); i++)
         check($sformatf("pp_order%0d", i), cap_q[i], 9'h110 + 9'(i));

      // Asynchronous reset during the enable pulse
      strobe(1'b1, 8'h55);
      strobe(1'b1, 8'h56);
      strobe(1'b1, 8'h57);
      check("arst_en_before", lcd_en, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_en", lcd_en, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_full", full, 1'b0);
      check("arst_ovf", overflow, 1'b0);
      check("arst_rs_data", {lcd_rs, lcd_data}, 9'h000);
      #1;
      reset_n = 1'b1;
      prev_en = 1'b0;
      tick(5);
      check("arst_empty_busy", busy, 1'b0);
      check("arst_empty_data", {lcd_en, lcd_rs, lcd_data}, 10'h000);

      // Stretched timing instance: two queued writes
      b_wr_strobe = 1'b1; b_wr_rs = 1'b1; b_wr_data = 8'h3C;
      tick(1);
      b_wr_data = 8'hC3;
      tick(1);
      b_wr_strobe = 1'b0;
      t = 1; t_d1 = -1; t_r1 = -1; t_f1 = -1; t_d2 = -1; t_r2 = -1; hi_tot = 0; rw_bad = 0;
      while (t <= 30) begin
         if (b_lcd_rw !== 1'b0) rw_bad++;
         if (b_lcd_data == 8'h3C && t_d1 < 0) t_d1 = t;
         if (b_lcd_data == 8'hC3 && t_d2 < 0) t_d2 = t;
         if (b_lcd_en) begin
            hi_tot++;
            if (t_r1 < 0) t_r1 = t;
            else if (t_d2 >= 0 && t_r2 < 0) t_r2 = t;
         end else if (t_r1 >= 0 && t_f1 < 0) begin
            t_f1 = t;
         end
         tick(1);
         t++;
      end
      check("slow_data1", t_d1, 1);
      check("slow_rise1", t_r1, 4);
      check("slow_fall1", t_f1, 6);
      check("slow_data2", t_d2, 13);
      check("slow_rise2", t_r2, 16);
      check("slow_en_hi", hi_tot, 4);
      check("slow_rw", rw_bad, 0);
      check("slow_idle", b_busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/k12a_lcd_ctrl.md
Name: k12a_lcd_ctrl

Overview:
Timing sequencer for the HD44780-style character LCD, sitting directly downstream of the I/O register block. It replaces direct software strobing of lcd_en. The I/O block hands it {rs, data} write requests through a single-cycle strobe. It buffers up to 4 requests, then drives each onto the LCD pins with correct setup, enable-pulse, hold and execution-wait timing, and reports busy/full/overflow status for the I/O block to expose on the data bus.

Parameters:
SETUP_CYCLES, 1, cycles rs/data are stable before lcd_en rises (>=1)
PULSE_CYCLES, 1, cycles lcd_en is high (>=1)
HOLD_CYCLES, 1, cycles rs/data are held after lcd_en falls (>=1)
EXEC_CYCLES, 40, post-write wait for normal commands/data (>=1)
LONG_EXEC_CYCLES, 1600, post-write wait for clear/home commands (>=1)
FIFO_DEPTH, 4, request buffer entries (power of 2, >=2)

Ports:
cpu_clock  input  1  system clock; all state on rising edge
reset_n  input  1  asynchronous, active-low reset
wr_strobe  input  1  one-cycle request to enqueue {wr_rs, wr_data}
wr_rs  input  1  0 = instruction, 1 = data
wr_data  input  8  byte to write
clr_overflow  input  1  clears the overflow flag
busy  output  1  FIFO non-empty or FSM not IDLE
full  output  1  FIFO holds FIFO_DEPTH entries
overflow  output  1  sticky: a strobe was dropped
lcd_rs  output  1  registered LCD register select
lcd_rw  output  1  constant 0 (write only)
lcd_en  output  1  registered LCD enable
lcd_data  output  8  registered LCD data bus

Behaviour:
- Reset (async, immediate): FIFO empty, state IDLE, counter 0, lcd_en=0, lcd_rs=0, lcd_data=0x00, overflow=0, busy=0, full=0. If reset is asserted mid-pulse, lcd_en drops without waiting for a clock edge.
- FIFO: 9-bit entries {rs, data}; first-in, first-out; pointers wrap modulo FIFO_DEPTH; occupancy count width is $clog2(FIFO_DEPTH)+1.
- Push: on a clock edge with wr_strobe=1, the entry is written if not full, or if full and a pop occurs on the same edge (count unchanged). Otherwise the entry is dropped and overflow is set.
- Overflow: clr_overflow=1 clears it. If a drop and clr_overflow coincide, the drop wins (overflow=1).
- FSM states: IDLE, SETUP, PULSE, HOLD, EXEC. A single down-counter is shared; each timed state lasts exactly its parameter count of cycles.
- IDLE: on an edge where the FIFO is non-empty, pop the head, load lcd_rs/lcd_data from it, go to SETUP (counter=SETUP_CYCLES-1). An entry pushed into an empty FIFO therefore appears on lcd_data one edge after the push edge.
- SETUP: lcd_en=0. When the counter reaches 0, go to PULSE and set lcd_en=1.
- PULSE: lcd_en=1. When the counter reaches 0, go to HOLD and set lcd_en=0.
- HOLD: lcd_rs/lcd_data are unchanged. When the counter reaches 0, go to EXEC.
- EXEC wait length: LONG_EXEC_CYCLES if the latched rs=0 and data is 0x01, 0x02 or 0x03 (clear/home); otherwise EXEC_CYCLES.
- EXEC: when the counter reaches 0, go to IDLE. lcd_rs/lcd_data keep their last values until the next pop.
- Back-to-back requests: the IDLE state occupies one cycle between transfers.
- lcd_en high time is exactly PULSE_CYCLES. Minimum total period per transfer is 1+SETUP+PULSE+HOLD+EXEC cycles.
- busy is combinational from registered state: (count!=0) | (state!=IDLE). full is combinational from count.
- Strobes are accepted in every FSM state. The FIFO is independent of the transfer in progress.
- Counter width is $clog2(max of all cycle parameters)+1.

Decomposition:
- Shared include k12a.inc.sv gains:
  - the lcd_state_t enum (IDLE, SETUP, PULSE, HOLD, EXEC);
  - constants LCD_CMD_CLEAR=8'h01 and LCD_CMD_HOME=8'h02;
  - the long-exec decode rule as a function.
- One sub-module, k12a_lcd_fifo: parameterised width and depth, with push/pop/full/empty/count. The FSM and counter stay in k12a_lcd_ctrl.

Test Plan:
- Reset then single strobe {rs=1, data=0x41} -> lcd_data=0x41 and lcd_rs=1 one edge later; lcd_en high for exactly 1 cycle after 1 setup cycle; busy clears after 1+1+1+1+40 cycles.
- Strobe {rs=0, data=0x01} -> EXEC lasts 1600 cycles. {rs=1, data=0x01} -> EXEC lasts 40 cycles.
- 6 strobes on consecutive cycles starting from empty -> full asserts; the 6th is dropped; overflow=1; exactly 5 transfers emerge in order (one popped immediately, 4 buffered). clr_overflow -> overflow=0.
- FIFO full and strobe coincident with a pop edge -> entry accepted, count stays 4, overflow stays 0.
- Assert reset_n=0 while lcd_en=1 -> lcd_en=0 without a clock edge; all outputs reset; the FIFO is empty after release.
- Parameters SETUP=3, PULSE=2, HOLD=2 -> lcd_data is stable ≥3 cycles before lcd_en rises and ≥2 cycles after it falls; lcd_rw is 0 throughout.
